egg_timer_core: RTL and testbench

Countdown controller that consumes the 500 Hz and 1 Hz single-cycle strobes from the clock divider. It holds the mm:ss setpoint as four BCD digits and accepts set/start/pause/clear commands from debounced buttons. It counts down once per 1 Hz strobe and raises a timed alarm at 00:00. Its digit outputs feed the seven-segment display scanner.

---
 rtl/egg_timer_core.sv | 198 +++++++++++++++++++
 tb/tb_egg_timer_core.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/egg_timer_core.sv
// Countdown controller for an mm:ss egg timer: BCD setpoint entry, 1 Hz countdown,
// and a timed, blinking alarm at 00:00.
module egg_timer_core #(
    parameter int MAX_MIN    = 99,
    parameter int ALARM_SECS = 10,
    parameter int BLINK_DIV  = 250
) (
    input  logic       clk_5MHz,
    input  logic       reset_n,
    input  logic       pulse_1Hz,
    input  logic       pulse_500Hz,
    input  logic       btn_start,
    input  logic       btn_min_inc,
    input  logic       btn_sec_inc,
    input  logic       btn_clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       alarm,
    output logic       alarm_blink,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        ALARM = 2'b11
    } state_t;

    localparam int ACW = $clog2(ALARM_SECS + 1);
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [3:0]     MAX_TENS   = 4'(MAX_MIN / 10);
    localparam logic [3:0]     MAX_ONES   = 4'(MAX_MIN % 10);
    localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_SECS - 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

    state_t         state_q, state_d;
    logic [3:0]     min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    logic [3:0]     dec_mt, dec_mo, dec_st, dec_so;
    logic           dec_zero, time_zero;
    logic [ACW-1:0] alarm_cnt, alarm_cnt_d;
    logic [BCW-1:0] blink_cnt, blink_cnt_d;
    logic           blink_phase, blink_phase_d;

    assign state       = state_q;
    assign running     = (state_q == RUN);
    assign alarm       = (state_q == ALARM);
    assign alarm_blink = alarm & blink_phase;
    assign time_zero   = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                         (sec_tens == 4'd0) && (sec_ones == 4'd0);

    // One-second BCD decrement with borrow rippling from seconds up into minutes
    always_comb begin
        dec_mt = min_tens;
        dec_mo = min_ones;
        dec_st = sec_tens;
        dec_so = sec_ones;
        if (sec_ones != 4'd0) begin
            dec_so = sec_ones - 4'd1;
        end else if (sec_tens != 4'd0) begin
            dec_st = sec_tens - 4'd1;
            dec_so = 4'd9;
        end else if (min_ones != 4'd0) begin
            dec_mo = min_ones - 4'd1;
            dec_st = 4'd5;
            dec_so = 4'd9;
        end else if (min_tens != 4'd0) begin
            dec_mt = min_tens - 4'd1;
            dec_mo = 4'd9;
            dec_st = 4'd5;
            dec_so = 4'd9;
        end
        dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
                   (dec_st == 4'd0) && (dec_so == 4'd0);
    end

    always_comb begin
        state_d       = state_q;
        min_tens_d    = min_tens;
        min_ones_d    = min_ones;
        sec_tens_d    = sec_tens;
        sec_ones_d    = sec_ones;
        alarm_cnt_d   = alarm_cnt;
        blink_cnt_d   = blink_cnt;
        blink_phase_d = blink_phase;

        case (state_q)
            IDLE: begin
                if (btn_clear) begin
                    {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} = 16'h0000;
                end else if (btn_start) begin
                    if (!time_zero) state_d = RUN;
                end else begin
                    if (btn_min_inc) begin
                        if (min_tens == MAX_TENS && min_ones == MAX_ONES) begin
                            min_tens_d = 4'd0;
                            min_ones_d = 4'd0;
                        end else if (min_ones == 4'd9) begin
                            min_tens_d = min_tens + 4'd1;
                            min_ones_d = 4'd0;
                        end else begin
                            min_ones_d = min_ones + 4'd1;
                        end
                    end
                    if (btn_sec_inc) begin
                        if (sec_tens == 4'd5 && sec_ones == 4'd9) begin
                            sec_tens_d = 4'd0;
                            sec_ones_d = 4'd0;
                        end else if (sec_ones == 4'd9) begin
                            sec_tens_d = sec_tens + 4'd1;
                            sec_ones_d = 4'd0;
                        end else begin
                            sec_ones_d = sec_ones + 4'd1;
                        end
                    end
                end
            end
            RUN: begin
                if (btn_clear) begin
                    state_d = IDLE;
                    {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} = 16'h0000;
                end else if (btn_start) begin
                    state_d = PAUSE;
                end else if (pulse_1Hz) begin
                    {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} = {dec_mt, dec_mo, dec_st, dec_so};
                    if (dec_zero) begin
                        state_d     = ALARM;
                        alarm_cnt_d = '0;
                    end
                end
            end
            PAUSE: begin
                if (btn_clear) begin
                    state_d = IDLE;
                    {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} = 16'h0000;
                end else if (btn_start) begin
                    state_d = RUN;
                end
            end
            ALARM: begin
                if (btn_clear || btn_start) begin
                    state_d     = IDLE;
                    alarm_cnt_d = '0;
                end else if (pulse_1Hz) begin
                    if (alarm_cnt == ALARM_LAST) begin
                        state_d     = IDLE;
                        alarm_cnt_d = '0;
                    end else begin
                        alarm_cnt_d = alarm_cnt + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Blink phase starts high on alarm entry so the display lights immediately
        if (state_d == ALARM && state_q != ALARM) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (state_d != ALARM) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (pulse_500Hz) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase;
            end else begin
                blink_cnt_d = blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_5MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            min_tens    <= 4'd0;
            min_ones    <= 4'd0;
            sec_tens    <= 4'd0;
            sec_ones    <= 4'd0;
            alarm_cnt   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_tens    <= min_tens_d;
            min_ones    <= min_ones_d;
            sec_tens    <= sec_tens_d;
            sec_ones    <= sec_ones_d;
            alarm_cnt   <= alarm_cnt_d;
            blink_cnt   <= blink_cnt_d;
            blink_phase <= blink_phase_d;
        end
    end

endmodule

// File: tb/tb_egg_timer_core.sv
// Self-checking bench for egg_timer_core: a seconds-based behavioural model compared
// every cycle, plus hand-computed checkpoints along a directed scenario.
`timescale 1ns/1ps
module tb_egg_timer_core;

    logic       clk_5MHz = 1'b0;
    logic       reset_n  = 1'b0;
    logic       pulse_1Hz = 1'b0, pulse_500Hz = 1'b0;
    logic       btn_start = 1'b0, btn_min_inc = 1'b0, btn_sec_inc = 1'b0, btn_clear = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, alarm, alarm_blink;
    logic [1:0] state;

    int checks   = 0;
    int errors   = 0;
    bit check_en = 1'b0;

    egg_timer_core #(.MAX_MIN(99), .ALARM_SECS(10), .BLINK_DIV(250)) dut (
        .clk_5MHz    (clk_5MHz),
        .reset_n     (reset_n),
        .pulse_1Hz   (pulse_1Hz),
        .pulse_500Hz (pulse_500Hz),
        .btn_start   (btn_start),
        .btn_min_inc (btn_min_inc),
        .btn_sec_inc (btn_sec_inc),
        .btn_clear   (btn_clear),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .alarm       (alarm),
        .alarm_blink (alarm_blink),
        .state       (state)
    );

    always #100 clk_5MHz = ~clk_5MHz;

    // Model: time as plain minutes/seconds, mode as 0..3, strobes seen since alarm entry
    typedef struct {
        int mins;
        int secs;
        int mode;
        int alarm_secs;
        int blink_strobes;
    } model_t;

    model_t m = '{0, 0, 0, 0, 0};

    function automatic model_t step(model_t cur, logic st, logic mi, logic si,
                                    logic cl, logic p1, logic p500);
        model_t n = cur;
        int t;
        case (cur.mode)
            0: begin
                if (cl) begin
                    n.mins = 0; n.secs = 0;
                end else if (st) begin
                    if (cur.mins * 60 + cur.secs != 0) n.mode = 1;
                end else begin
                    if (mi) n.mins = (cur.mins + 1) % 100;
                    if (si) n.secs = (cur.secs + 1) % 60;
                end
            end
            1: begin
                if (cl) begin
                    n.mode = 0; n.mins = 0; n.secs = 0;
                end else if (st) begin
                    n.mode = 2;
                end else if (p1) begin
                    t = cur.mins * 60 + cur.secs - 1;
                    n.mins = t / 60;
                    n.secs = t % 60;
                    if (t == 0) begin
                        n.mode = 3; n.alarm_secs = 0; n.blink_strobes = 0;
                    end
                end
            end
            2: begin
                if (cl) begin
                    n.mode = 0; n.mins = 0; n.secs = 0;
                end else if (st) begin
                    n.mode = 1;
                end
            end
            default: begin
                if (cl || st) begin
                    n.mode = 0;
                end else begin
                    if (p500) n.blink_strobes = cur.blink_strobes + 1;
                    if (p1) begin
                        n.alarm_secs = cur.alarm_secs + 1;
                        if (n.alarm_secs == 10) n.mode = 0;
                    end
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk_5MHz or negedge reset_n) begin
        if (!reset_n)
            m <= '{0, 0, 0, 0, 0};
        else
            m <= step(m, btn_start, btn_min_inc, btn_sec_inc, btn_clear, pulse_1Hz, pulse_500Hz);
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every mid-cycle, all outputs against the model
    always @(negedge clk_5MHz) begin
        if (check_en) begin
            check_output("model min_tens", int'(min_tens), m.mins / 10);
            check_output("model min_ones", int'(min_ones), m.mins % 10);
            check_output("model sec_tens", int'(sec_tens), m.secs / 10);
            check_output("model sec_ones", int'(sec_ones), m.secs % 10);
            check_output("model state", int'(state), m.mode);
            check_output("model running", int'(running), int'(m.mode == 1));
            check_output("model alarm", int'(alarm), int'(m.mode == 3));
            check_output("model alarm_blink", int'(alarm_blink),
                         int'(m.mode == 3 && ((m.blink_strobes / 250) % 2) == 0));
        end
    end

    task automatic apply_stimulus(input logic st, input logic mi, input logic si,
                                  input logic cl, input logic p1, input logic p500);
        btn_start   = st;
        btn_min_inc = mi;
        btn_sec_inc = si;
        btn_clear   = cl;
        pulse_1Hz   = p1;
        pulse_500Hz = p500;
        @(posedge clk_5MHz);
        #1;
        {btn_start, btn_min_inc, btn_sec_inc, btn_clear, pulse_1Hz, pulse_500Hz} = 6'b0;
    endtask

    task automatic check_time(input string name, input int mt, input int mo, input int st, input int so);
        check_output({name, " min_tens"}, int'(min_tens), mt);
        check_output({name, " min_ones"}, int'(min_ones), mo);
        check_output({name, " sec_tens"}, int'(sec_tens), st);
        check_output({name, " sec_ones"}, int'(sec_ones), so);
    endtask

    initial begin
        #1 check_en = 1'b1;
        repeat (2) @(posedge clk_5MHz);
        #1 reset_n = 1'b1;
        check_time("reset", 0, 0, 0, 0);
        check_output("reset state", int'(state), 0);
        check_output("reset alarm", int'(alarm), 0);

        repeat (3) apply_stimulus(0, 1, 0, 0, 0, 0);
        repeat (2) apply_stimulus(0, 0, 1, 0, 0, 0);
        check_time("entry 03:02", 0, 3, 0, 2);
        check_output("entry state", int'(state), 0);
        apply_stimulus(0, 1, 1, 0, 0, 0);
        check_time("dual inc 04:03", 0, 4, 0, 3);

        apply_stimulus(0, 0, 0, 1, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 0);
        check_time("first tick 00:59", 0, 0, 5, 9);
        check_output("first tick running", int'(running), 1);
        repeat (58) apply_stimulus(0, 0, 0, 0, 1, 0);
        check_time("last before zero", 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 1, 0);
        check_output("zero state", int'(state), 3);
        check_output("zero alarm", int'(alarm), 1);
        check_output("entry blink", int'(alarm_blink), 1);

        repeat (249) apply_stimulus(0, 0, 0, 0, 0, 1);
        check_output("blink 249 strobes", int'(alarm_blink), 1);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        check_output("blink 250 strobes", int'(alarm_blink), 0);
        repeat (250) apply_stimulus(0, 0, 0, 0, 0, 1);
        check_output("blink 500 strobes", int'(alarm_blink), 1);
        apply_stimulus(0, 1, 1, 0, 0, 0);
        check_time("alarm ignores inc", 0, 0, 0, 0);
        repeat (9) apply_stimulus(0, 0, 0, 0, 1, 0);
        check_output("alarm after 9", int'(alarm), 1);
        apply_stimulus(0, 0, 0, 0, 1, 0);
        check_output("alarm after 10 state", int'(state), 0);
        check_output("alarm after 10 alarm", int'(alarm), 0);
        check_output("alarm after 10 blink", int'(alarm_blink), 0);

        repeat (10) apply_stimulus(0, 0, 1, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 1, 0);
        check_output("pause state", int'(state), 2);
        check_time("pause 00:10", 0, 0, 1, 0);
        repeat (5) apply_stimulus(0, 1, 1, 0, 1, 0);
        check_time("paused frozen", 0, 0, 1, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 0);
        check_time("resume 00:09", 0, 0, 0, 9);
        apply_stimulus(0, 0, 0, 1, 0, 0);
        check_output("clear from run", int'(state), 0);

        repeat (99) apply_stimulus(0, 1, 0, 0, 0, 0);
        check_time("min 99", 9, 9, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0, 0);
        check_time("min wrap", 0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0, 0);
        repeat (59) apply_stimulus(0, 0, 1, 0, 0, 0);
        check_time("sec 59", 0, 1, 5, 9);
        apply_stimulus(0, 0, 1, 0, 0, 0);
        check_time("sec wrap no carry", 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_output("start at zero", int'(state), 0);

        apply_stimulus(0, 0, 1, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 0);
        check_output("short alarm", int'(state), 3);
        apply_stimulus(0, 0, 0, 1, 0, 0);
        check_output("clear from alarm", int'(state), 0);

        repeat (12) apply_stimulus(0, 1, 0, 0, 0, 0);
        repeat (34) apply_stimulus(0, 0, 1, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_time("run 12:34", 1, 2, 3, 4);
        check_output("run 12:34 state", int'(state), 1);
        #20 reset_n = 1'b0;
        #5;
        check_time("async reset", 0, 0, 0, 0);
        check_output("async reset state", int'(state), 0);
        check_output("async reset running", int'(running), 0);
        @(posedge clk_5MHz);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk_5MHz);
        #1 check_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
